// File: rtl/planar_shifter.sv
// planar_shifter: bitplane-to-chunky pixel shifter with palette, mode and scroll registers
module planar_shifter #(
    parameter int MAX_PLANES = 4,
    parameter int CH_BITS = 4,
    localparam int ENTRIES = 2**MAX_PLANES,
    localparam int ADDR_W = $clog2(ENTRIES + 2)
) (
    input  logic               CLOCK_32,
    input  logic               reset,
    input  logic               de,
    input  logic               load_n,
    input  logic               cs_n,
    input  logic               rw,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [15:0]        data_in,
    output logic [15:0]        data_out,
    output logic               data_oe,
    output logic [CH_BITS-1:0] r,
    output logic [CH_BITS-1:0] g,
    output logic [CH_BITS-1:0] b
);
    localparam int CW = 3 * CH_BITS;
    localparam int LOG_P = $clog2(MAX_PLANES);
    localparam int LW = (LOG_P > 0) ? LOG_P : 1;
    localparam logic [1:0] MODE_MAX = 2'(LOG_P);
    localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(ENTRIES);
    localparam logic [ADDR_W-1:0] A_SCROLL = ADDR_W'(ENTRIES + 1);
    logic [CW-1:0]         pal [ENTRIES];
    logic [15:0]           lat [MAX_PLANES];
    logic [15:0]           grp [MAX_PLANES];
    logic [31:0]           sh [MAX_PLANES];
    logic [1:0]            mode, mode_c;
    logic [3:0]            scroll, lc, div, pc, planes;
    logic                  pend, load_q, wr, mode_wr, load_ev, done, tick, wrap, use_grp;
    logic [MAX_PLANES-1:0] idx;
    logic [15:0]           rd;
    always_comb begin
        mode_c = (mode > MODE_MAX) ? MODE_MAX : mode;
        planes = 4'(MAX_PLANES >> mode_c);
        wr = ~cs_n & ~rw;
        mode_wr = wr & (addr == A_MODE);
        load_ev = de & load_q & ~load_n & ~mode_wr;
        done = load_ev & (lc == planes - 4'd1);
        tick = de & (div == planes - 4'd1);
        wrap = tick & (pc == 4'd15);
        use_grp = wrap & (pend | done);
        for (int p = 0; p < MAX_PLANES; p++) begin
            grp[p] = (load_ev && lc == 4'(p)) ? data_in : lat[p];
            idx[p] = (4'(p) < planes) && sh[p][5'd15 + 5'(scroll)];
        end
        rd = (addr < A_MODE) ? 16'(pal[addr[MAX_PLANES-1:0]]) :
             (addr == A_MODE) ? {14'd0, mode} :
             (addr == A_SCROLL) ? {12'd0, scroll} : 16'd0;
        data_oe = ~cs_n & rw;
        data_out = data_oe ? rd : 16'd0;
    end
    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) pal[i] <= '0;
            for (int p = 0; p < MAX_PLANES; p++) begin
                lat[p] <= '0;
                sh[p] <= '0;
            end
            mode <= '0;
            scroll <= '0;
            lc <= '0;
            div <= '0;
            pc <= '0;
            pend <= 1'b0;
            load_q <= 1'b0;
            {r, g, b} <= '0;
        end else begin
            load_q <= load_n;
            if (wr && addr < A_MODE) pal[addr[MAX_PLANES-1:0]] <= data_in[CW-1:0];
            if (mode_wr) mode <= data_in[1:0];
            if (wr && addr == A_SCROLL) scroll <= data_in[3:0];
            {r, g, b} <= de ? pal[idx] : pal[0];
            if (!de) begin
                lc <= '0;
                div <= '0;
                pc <= '0;
                pend <= 1'b0;
                for (int p = 0; p < MAX_PLANES; p++) sh[p] <= '0;
            end else begin
                div <= (tick || mode_wr) ? 4'd0 : div + 4'd1;
                pc <= tick ? pc + 4'd1 : pc;
                lc <= (mode_wr || done) ? 4'd0 : load_ev ? lc + 4'd1 : lc;
                pend <= !mode_wr && !wrap && (pend || done);
                if (load_ev) lat[lc[LW-1:0]] <= data_in;
                for (int p = 0; p < MAX_PLANES; p++)
                    if (tick) sh[p] <= wrap ? {sh[p][30:15], use_grp ? grp[p] : 16'd0} : {sh[p][30:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_planar_shifter.sv
// tb_planar_shifter: scenario tasks with a queue scoreboard of expected pixel colours
module tb_planar_shifter;
    logic        CLOCK_32 = 1'b0;
    logic        reset, de, load_n, cs_n, rw;
    logic [4:0]  addr;
    logic [15:0] data_in, data_out;
    logic        data_oe;
    logic [3:0]  r, g, b;
    logic [11:0] pix;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] sb [$];
    int          tq [$];
    planar_shifter dut (
        .CLOCK_32(CLOCK_32), .reset(reset), .de(de), .load_n(load_n), .cs_n(cs_n), .rw(rw),
        .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .r(r), .g(g), .b(b)
    );
    assign pix = {r, g, b};
    always #5 CLOCK_32 = ~CLOCK_32;
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_32);
            #1;
        end
    endtask
    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        cs_n = 1'b0; rw = 1'b0; addr = a; data_in = d;
        step();
        cs_n = 1'b1; rw = 1'b1;
    endtask
    task automatic load(input logic [15:0] d);
        data_in = d; load_n = 1'b0;
        step();
        load_n = 1'b1;
        step();
    endtask
    task automatic wait_pix(input int lim, output int t);
        t = 0;
        while (pix === 12'h000 && t < lim) begin
            step();
            t++;
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        step(3);
        n_cmp++; if (pix !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h expected 000", pix); end
        cs_n = 1'b0; rw = 1'b1; addr = 5'd16; #1;
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_read: oe=%b data=%h expected oe=1 data=0000", data_oe, data_out); end
        cs_n = 1'b1; #1;
        n_cmp++; if (data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", data_oe); end
        reset = 1'b0;
        step();
    endtask
    task automatic test_regs();
        logic [4:0]  ra [6] = '{5'd15, 5'd17, 5'd2, 5'd20, 5'd16, 5'd0};
        logic [15:0] rx [6] = '{16'h0FFF, 16'h0005, 16'h0ABC, 16'h0000, 16'h0003, 16'h0000};
        wr(5'd15, 16'h0FFF);
        wr(5'd17, 16'h0005);
        wr(5'd2, 16'hFABC);
        wr(5'd20, 16'hFFFF);
        wr(5'd16, 16'h0007);
        for (int i = 0; i < 6; i++) begin
            cs_n = 1'b0; rw = 1'b1; addr = ra[i]; #1;
            n_cmp++; if (data_oe !== 1'b1 || data_out !== rx[i]) begin n_bad++; $display("FAIL reg_read[%0d]: oe=%b data=%h expected oe=1 data=%h", ra[i], data_oe, data_out, rx[i]); end
        end
        cs_n = 1'b1; addr = 5'd15; #1;
        n_cmp++; if (data_oe !== 1'b0 || data_out !== 16'h0000) begin n_bad++; $display("FAIL reg_idle: oe=%b data=%h expected oe=0 data=0000", data_oe, data_out); end
        wr(5'd17, 16'd0);
        wr(5'd16, 16'd0);
    endtask
    task automatic test_mode0();
        int t;
        logic [11:0] exp;
        de = 1'b1;
        repeat (4) load(16'hFFFF);
        repeat (64) sb.push_back(12'hFFF);
        sb.push_back(12'h000);
        wait_pix(200, t);
        n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL mode0_start: waited %0d clocks, required pixel within 200", t); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_cmp++; if (pix !== exp) begin n_bad++; $display("FAIL mode0_pixel: got %h expected %h", pix, exp); end
            step();
        end
        de = 1'b0;
        step();
    endtask
    task automatic test_border();
        int t;
        logic [11:0] exp;
        wr(5'd1, 16'h0FFF);
        de = 1'b1;
        repeat (4) load(16'hFFFF);
        wait_pix(200, t);
        step(3);
        n_cmp++; if (pix !== 12'hFFF) begin n_bad++; $display("FAIL border_show: got %h expected fff", pix); end
        repeat (6) load(16'hFFFF);
        de = 1'b0;
        step();
        n_cmp++; if (pix !== 12'h000) begin n_bad++; $display("FAIL border_color: got %h expected 000", pix); end
        repeat (2) load(16'hFFFF);
        de = 1'b1;
        for (int i = 0; i < 140; i++) begin
            n_cmp++; if (pix !== 12'h000) begin n_bad++; $display("FAIL border_stale[%0d]: got %h expected 000", i, pix); end
            step();
        end
        load(16'hFFFF); load(16'h0000); load(16'h0000); load(16'h0000);
        repeat (64) sb.push_back(12'hFFF);
        sb.push_back(12'h000);
        wait_pix(200, t);
        n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL border_fresh: waited %0d clocks, required pixel within 200", t); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_cmp++; if (pix !== exp) begin n_bad++; $display("FAIL border_pixel: got %h expected %h", pix, exp); end
            step();
        end
        de = 1'b0;
        step();
    endtask
    task automatic test_mode1();
        int t;
        logic [11:0] exp;
        wr(5'd3, 16'h0FFF);
        wr(5'd16, 16'h0001);
        de = 1'b1;
        load(16'hAAAA);
        load(16'hAAAA);
        for (int i = 0; i < 16; i++) repeat (2) sb.push_back(i[0] ? 12'h000 : 12'hFFF);
        repeat (2) sb.push_back(12'h000);
        wait_pix(100, t);
        n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL mode1_start: waited %0d clocks, required pixel within 100", t); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_cmp++; if (pix !== exp) begin n_bad++; $display("FAIL mode1_pixel: got %h expected %h", pix, exp); end
            step();
        end
        de = 1'b0;
        step();
    endtask
    task automatic test_scroll();
        int t, exp;
        for (int k = 0; k < 3; k++) begin
            wr(5'd16, (k == 2) ? 16'd3 : 16'd2);
            wr(5'd17, (k == 1) ? 16'd3 : 16'd0);
            de = 1'b1;
            load(16'h8000);
            wait_pix(100, t);
            if (k == 0) begin
                n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL scroll_start: waited %0d clocks, required pixel within 100", t); end
                tq.push_back(t + 3);
                tq.push_back(t);
            end else begin
                exp = tq.pop_front();
                n_cmp++; if (t !== exp) begin n_bad++; $display("FAIL scroll_delay[%0d]: pixel after %0d clocks, expected %0d", k, t, exp); end
            end
            n_cmp++; if (pix !== 12'hFFF) begin n_bad++; $display("FAIL scroll_pixel[%0d]: got %h expected fff", k, pix); end
            step();
            n_cmp++; if (pix !== 12'h000) begin n_bad++; $display("FAIL scroll_width[%0d]: got %h expected 000", k, pix); end
            de = 1'b0;
            step();
        end
        wr(5'd17, 16'd0);
        wr(5'd16, 16'd0);
    endtask
    task automatic test_reset_mid();
        int t;
        logic [11:0] exp;
        wr(5'd0, 16'h0123);
        step();
        n_cmp++; if (pix !== 12'h123) begin n_bad++; $display("FAIL rmid_border: got %h expected 123", pix); end
        de = 1'b1;
        load(16'hFFFF);
        load(16'hFFFF);
        reset = 1'b1; load_n = 1'b0; data_in = 16'h5555; cs_n = 1'b0; rw = 1'b0; addr = 5'd1;
        step();
        n_cmp++; if (pix !== 12'h000) begin n_bad++; $display("FAIL rmid_rgb: got %h expected 000", pix); end
        rw = 1'b1; addr = 5'd0; #1;
        n_cmp++; if (data_oe !== 1'b1 || data_out !== 16'h0000) begin n_bad++; $display("FAIL rmid_pal0: oe=%b data=%h expected oe=1 data=0000", data_oe, data_out); end
        addr = 5'd1; #1;
        n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL rmid_pal1: got %h expected 0000", data_out); end
        cs_n = 1'b1;
        reset = 1'b0;
        step();
        load_n = 1'b1;
        step();
        wr(5'd1, 16'h0FFF);
        load(16'hFFFF); load(16'h0000); load(16'h0000); load(16'h0000);
        repeat (64) sb.push_back(12'hFFF);
        sb.push_back(12'h000);
        wait_pix(200, t);
        n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL rmid_start: waited %0d clocks, required pixel within 200", t); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_cmp++; if (pix !== exp) begin n_bad++; $display("FAIL rmid_pixel: got %h expected %h", pix, exp); end
            step();
        end
        de = 1'b0;
        step();
    endtask
    initial begin
        reset = 1'b1; de = 1'b0; load_n = 1'b1; cs_n = 1'b1; rw = 1'b1; addr = '0; data_in = '0;
        test_reset();
        test_regs();
        test_mode0();
        test_border();
        test_mode1();
        test_scroll();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
